// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, fetch FSM states and the prefetch entry layout.
package riscv_pkg;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_S = 7'b0100011;
    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [6:0] OPC_U = 7'b0110111;
    localparam logic [6:0] OPC_J = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit boundary: decode handshake, execute redirect, imem read channel and perf counters.
// master = fetch unit side, slave = the surrounding pipeline / memory.
interface fetch_unit_if;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [31:0] fetch_cnt_out;
    logic [31:0] stall_cnt_out;

    modport master (
        input  stall_in, redirect_in, redirect_pc_in, imem_ack_in, imem_rdata_in,
        output imem_req_out, imem_addr_out, instr_out, pc_out, valid_out,
        fetch_cnt_out, stall_cnt_out
    );

    modport slave (
        output stall_in, redirect_in, redirect_pc_in, imem_ack_in, imem_rdata_in,
        input  imem_req_out, imem_addr_out, instr_out, pc_out, valid_out,
        fetch_cnt_out, stall_cnt_out
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr,pc}; head visible the cycle after push, flush empties it on the same edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch (FETCH_PERF_CNT_EN adds perf counters); a word reaches valid_out the cycle after its imem ack.
// Backpressure: stall_in holds the head; imem requests stop while the FIFO has no room for the response.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input logic          req,
    input logic          reset,
    fetch_unit_if.master fu
);
    import riscv_pkg::*;

    localparam int         CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_REQ      = REQ;
    localparam logic [1:0] ST_DISCARD  = DISCARD;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   pc;
    logic [31:0]   addr_hold;
    logic [CW-1:0] count;
    logic          valid;
    logic          ack;
    logic          push;
    logic          pop;
    logic          room_after;
    fetch_entry_t  push_dat;
    fetch_entry_t  head;

    assign valid      = (count != '0);
    assign pop        = valid && !fu.stall_in && !fu.redirect_in;
    assign ack        = (state != ST_IDLE) && fu.imem_ack_in;
    assign push       = (state == ST_REQ) && ack && !fu.redirect_in;
    assign room_after = (int'(count) + int'(push) - int'(pop)) < FIFO_DEPTH;
    assign push_dat   = {fu.imem_rdata_in, pc};

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (int'(count) < FIFO_DEPTH) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (ack)                 state_nxt = (!fu.redirect_in && room_after) ? ST_REQ : ST_IDLE;
                else if (fu.redirect_in) state_nxt = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // addr_hold keeps the in-flight address stable while pc already follows the redirect
    always_ff @(posedge req) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            addr_hold <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (state == ST_REQ && state_nxt == ST_DISCARD) addr_hold <= pc;
            if (fu.redirect_in) pc <= fu.redirect_pc_in & ~32'd3;
            else if (push)      pc <= pc + 32'd4;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (req),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (fu.redirect_in),
        .head_dat (head),
        .count    (count)
    );

    assign fu.imem_req_out  = (state != ST_IDLE);
    assign fu.imem_addr_out = (state == ST_DISCARD) ? addr_hold : pc;
    assign fu.valid_out     = valid;
    assign fu.instr_out     = valid ? head.instr : NOP_INSTR;
    assign fu.pc_out        = valid ? head.pc : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge req) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop)                 fetch_cnt <= fetch_cnt + 32'd1;
            if (valid && fu.stall_in) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign fu.fetch_cnt_out = fetch_cnt;
    assign fu.stall_cnt_out = stall_cnt;
`else
    assign fu.fetch_cnt_out = 32'h0;
    assign fu.stall_cnt_out = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected words queued by the stimulus, consumed words checked by a monitor.
module tb_fetch_unit;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          consec;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if fu();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .req   (clk),
        .reset (reset),
        .fu    (fu)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   lat      = 1;
    int   wait_cnt = 0;
    bit   mon_en   = 1'b0;
    bit   hold_pend = 1'b0;
    logic [31:0] hold_addr = '0;
    exp_t q[$];

    // imem model: acks in the lat-th cycle of a request, returns addr>>2
    assign fu.imem_ack_in   = fu.imem_req_out && (wait_cnt >= lat - 1);
    assign fu.imem_rdata_in = fu.imem_addr_out >> 2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset)                                  wait_cnt <= 0;
        else if (fu.imem_req_out && !fu.imem_ack_in) wait_cnt <= wait_cnt + 1;
        else                                        wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && hold_pend) begin
            chk("imem_req_held", {31'd0, fu.imem_req_out}, 32'd1);
            chk("imem_addr_stable", fu.imem_addr_out, hold_addr);
        end
        hold_pend = !reset && fu.imem_req_out && !fu.imem_ack_in;
        hold_addr = fu.imem_addr_out;
        if (mon_en && !reset && fu.valid_out && !fu.stall_in && !fu.redirect_in) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got pc %h instr %h, nothing expected", fu.pc_out, fu.instr_out);
            end else begin
                e = q.pop_front();
                chk("pop_pc", fu.pc_out, e.pc);
                chk("pop_instr", fu.instr_out, e.instr);
                if (e.consec) chk("pop_back_to_back", 32'(cyc), 32'(last_cyc + 1));
            end
            last_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1;
        fu.stall_in = 1'b1;
        fu.redirect_in = 1'b0;
        fu.redirect_pc_in = '0;
        tick();
        tick();
        if (check) begin
            chk("rst_valid", {31'd0, fu.valid_out}, 32'd0);
            chk("rst_req", {31'd0, fu.imem_req_out}, 32'd0);
            chk("rst_addr", fu.imem_addr_out, 32'h0);
            chk("rst_instr", fu.instr_out, 32'h0000_0013);
            chk("rst_pc", fu.pc_out, 32'h0);
            chk("rst_fetch_cnt", fu.fetch_cnt_out, 32'h0);
            chk("rst_stall_cnt", fu.stall_cnt_out, 32'h0);
        end
        reset = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc, input bit consec);
        exp_t e;
        e.instr = instr;
        e.pc = pc;
        e.consec = consec;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        chk(name, 32'(q.size()), 32'd0);
        fu.stall_in = 1'b1;
        q.delete();
    endtask

    // waits for the first request cycle, then redirects in that cycle
    task automatic redirect_on_req(input string name, input logic [31:0] target);
        bit found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (fu.imem_req_out) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(name, {31'd0, found}, 32'd1);
        fu.redirect_in = 1'b1;
        fu.redirect_pc_in = target;
        tick();
        fu.redirect_in = 1'b0;
    endtask

    initial begin
        bit found;
        int pops;
        int stalls;
        reset = 1'b1;
        fu.stall_in = 1'b1;
        fu.redirect_in = 1'b0;
        fu.redirect_pc_in = '0;

        // sequential fetch, one word per cycle
        lat = 1;
        do_reset(1'b1);
        expect_word(32'd0, 32'd0, 1'b0);
        expect_word(32'd1, 32'd4, 1'b1);
        expect_word(32'd2, 32'd8, 1'b1);
        expect_word(32'd3, 32'd12, 1'b1);
        mon_en = 1'b1;
        fu.stall_in = 1'b0;
        drain("t1_drain");

        // decode stall at pc 8
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) expect_word(32'(i), 32'(4 * i), 1'b0);
        fu.stall_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fu.valid_out && fu.pc_out == 32'd8) begin
                found = 1'b1;
                break;
            end
        end
        fu.stall_in = 1'b1;
        chk("t2_head_pc8_seen", {31'd0, found}, 32'd1);
        repeat (5) tick();
        chk("t2_hold_valid", {31'd0, fu.valid_out}, 32'd1);
        chk("t2_hold_pc", fu.pc_out, 32'd8);
        chk("t2_hold_instr", fu.instr_out, 32'd2);
        chk("t2_full_req_low", {31'd0, fu.imem_req_out}, 32'd0);
        fu.stall_in = 1'b0;
        drain("t2_drain");

        // redirect with an ack still outstanding
        lat = 3;
        do_reset(1'b0);
        expect_word(32'h40, 32'h100, 1'b0);
        expect_word(32'h41, 32'h104, 1'b0);
        fu.stall_in = 1'b0;
        redirect_on_req("t3_req_seen", 32'h100);
        chk("t3_discard_req", {31'd0, fu.imem_req_out}, 32'd1);
        chk("t3_discard_addr", fu.imem_addr_out, 32'h0);
        chk("t3_flushed", {31'd0, fu.valid_out}, 32'd0);
        drain("t3_drain");

        // redirect coinciding with ack, unaligned target
        lat = 1;
        do_reset(1'b0);
        expect_word(32'h80, 32'h200, 1'b0);
        expect_word(32'h81, 32'h204, 1'b0);
        fu.stall_in = 1'b0;
        redirect_on_req("t4_req_seen", 32'h203);
        chk("t4_no_push", {31'd0, fu.valid_out}, 32'd0);
        chk("t4_idle", {31'd0, fu.imem_req_out}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fu.imem_req_out) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_refetch_seen", {31'd0, found}, 32'd1);
        chk("t4_refetch_addr", fu.imem_addr_out, 32'h200);
        drain("t4_drain");

        // pc wraps past the top of the address space
        do_reset(1'b0);
        expect_word(32'h3FFF_FFFE, 32'hFFFF_FFF8, 1'b0);
        expect_word(32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b0);
        expect_word(32'h0, 32'h0, 1'b0);
        fu.stall_in = 1'b0;
        redirect_on_req("t7_req_seen", 32'hFFFF_FFF8);
        drain("t7_drain");

        // reset while a request is in flight and the FIFO holds data
        lat = 3;
        do_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fu.valid_out && fu.imem_req_out) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_busy_seen", {31'd0, found}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_valid", {31'd0, fu.valid_out}, 32'd0);
        chk("t5_req", {31'd0, fu.imem_req_out}, 32'd0);
        chk("t5_addr", fu.imem_addr_out, 32'h0);
        chk("t5_instr", fu.instr_out, 32'h0000_0013);
        reset = 1'b0;
        expect_word(32'd0, 32'd0, 1'b0);
        fu.stall_in = 1'b0;
        drain("t5_drain");

        // perf counters: 10 pops, 3 stalled cycles
        lat = 1;
        do_reset(1'b0);
        mon_en = 1'b0;
        pops = 0;
        stalls = 0;
        for (int i = 0; i < 200 && pops < 10; i++) begin
            fu.stall_in = (pops >= 4 && stalls < 3);
            if (fu.valid_out) begin
                if (fu.stall_in) stalls++;
                else             pops++;
            end
            tick();
        end
        fu.stall_in = 1'b0;
        fu.redirect_in = 1'b1;
        fu.redirect_pc_in = 32'h400;
        chk("t6_pop_budget", 32'(pops), 32'd10);
        repeat (3) tick();
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fetch_cnt", fu.fetch_cnt_out, 32'd10);
        chk("t6_stall_cnt", fu.stall_cnt_out, 32'd3);
`else
        chk("t6_fetch_cnt", fu.fetch_cnt_out, 32'd0);
        chk("t6_stall_cnt", fu.stall_cnt_out, 32'd0);
`endif
        fu.redirect_in = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
